keypad_operand_loader: RTL and testbench
========================================

Name: keypad_operand_loader

Overview:
- Upstream stage of the accumulator registers: scans a 4x4 hex keypad, debounces it and encodes the accepted key to a 4-bit value.
- Sequences operand entry. The first accepted key goes to accumulator A, the second to accumulator B, then the block reports operands ready.
- Drives the accumulators' kbd[3:0] data bus and their LatchA/LatchB enables.
- LatchB is ANDed with MainClock downstream, so every latch output is a registered, glitch-free, single-cycle pulse.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a press or a release (legal 1..15).
- SCAN_DIV, 1: MainClock cycles each column stays driven while scanning (legal 1..15).

Ports:
- MainClock  in  1  sole clock, rising edge.
- ClearN  in  1  synchronous active-low reset.
- Row  in  4  keypad rows, active-low, pulled up externally; treated as already synchronised.
- Col  out  4  column drive, active-low one-hot; exactly one bit low at all times after reset.
- kbd  out  4  encoded key value, registered.
- LatchA  out  1  one-cycle pulse, load accumulator A.
- LatchB  out  1  one-cycle pulse, load accumulator B.
- OperandsValid  out  1  high while both operands are loaded.
- Restart  in  1  one-cycle request to begin a new entry sequence.

Behaviour:
- Reset (ClearN low at an edge): Col=4'b1110 (column 0), kbd=0, LatchA=0, LatchB=0, OperandsValid=0, scanner state SCAN, sequencer state WAIT_A, debounce counter 0.
- Scanner FSM: SCAN -> PRESS_DB -> HELD -> RELEASE_DB -> SCAN.
  - SCAN: column index advances 0,1,2,3,0 every SCAN_DIV cycles while Row==4'hF. Any Row bit low freezes the column and enters PRESS_DB with count=1.
  - PRESS_DB: count increments while the Row pattern equals the captured pattern.
    - A pattern change that is not all-high restarts count at 1 with the new pattern.
    - Row==4'hF returns to SCAN with the column unchanged.
    - count==DEBOUNCE_CYCLES accepts the key: code = 4*row_idx + col_idx, where row_idx is the lowest-indexed low row bit. Then HELD.
  - HELD: wait for Row==4'hF, then RELEASE_DB.
  - RELEASE_DB: DEBOUNCE_CYCLES consecutive all-high cycles return to SCAN, with the column advanced by one. Any low bit returns to HELD and does not produce a new acceptance.
- Accept/latch timing: kbd is loaded with the code on the accept edge (cycle N). The latch pulse is high during cycle N+1 only. kbd holds its value until the next accepted key, so it is stable one full cycle before and during the pulse.
- Sequencer FSM:
  - WAIT_A: accept -> pulse LatchA, go to WAIT_B.
  - WAIT_B: accept -> pulse LatchB, go to DONE.
  - DONE: OperandsValid=1; further key accepts are ignored (kbd not updated, no pulses).
  - Restart in DONE -> WAIT_A with OperandsValid cleared next cycle.
  - Restart in WAIT_A or WAIT_B -> WAIT_A; an operand already latched is not cleared.
- Restart on the same edge as an accept: Restart wins. The accept is discarded, no pulse, kbd unchanged.
- LatchA and LatchB are never high in the same cycle; at most one pulse per accepted key.
- Reset mid-debounce or mid-pulse: everything returns to reset values on that edge; a pulse in flight is cut.

Optional Feature:
- Macro KEYPAD_CLEAR_KEY_EN.
- Defined:
  - Key code 4'hF is a clear key. It never loads kbd and never pulses LatchA or LatchB.
  - In any sequencer state it forces WAIT_A and drives a one-cycle active-low pulse on added output ClearOut (1 bit, reset value 1). ClearOut feeds the accumulators' ClearA/ClearB inputs.
  - Timing matches the latch pulses: accept at cycle N, ClearOut low during N+1.
- Not defined: 4'hF is ordinary data value 15 and the ClearOut port does not exist.

Decomposition:
- Package keypad_pkg holds:
  - scanner state enum {SCAN, PRESS_DB, HELD, RELEASE_DB};
  - sequencer enum {WAIT_A, WAIT_B, DONE};
  - NUM_ROWS=4, NUM_COLS=4;
  - CLEAR_KEY_CODE=4'hF.
- Sub-module keypad_debounce: captured pattern, stability counter, press/release accept strobes.
- The top level holds column scan, encoding and sequencer.

Test Plan:
- Reset, no keys, SCAN_DIV=1 -> Col cycles 1110,1101,1011,0111,1110 on consecutive cycles; all outputs at reset values.
- Key row1/col2 held 10 cycles, DEBOUNCE_CYCLES=4 -> kbd=4'h6 on accept edge, LatchA high exactly one cycle later. Then key row3/col0 -> kbd=4'hC, LatchB pulse, OperandsValid=1.
- Press bouncing (low 2 cycles, high 1, low 6) -> exactly one accept, timed from the final low run. Release bounce (high 2, low 1, high 5) -> no second accept.
- In DONE, press key 4'h3 -> kbd stays 4'hC, no pulse. Restart pulse -> OperandsValid=0 next cycle; next key pulses LatchA.
- ClearN low during PRESS_DB count=3 -> all outputs at reset values the next cycle, Col=1110, no latch pulse.
- With KEYPAD_CLEAR_KEY_EN, after LatchA load press row3/col3 -> ClearOut low one cycle, state WAIT_A, kbd unchanged, no LatchB.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Types and constants shared by the keypad operand loader.
//   - scan_state_t : scanner/debounce FSM states
//   - seq_state_t  : operand entry sequencer states
//   - NUM_ROWS / NUM_COLS : keypad matrix geometry
//   - CLEAR_KEY_CODE : code used as the clear key when KEYPAD_CLEAR_KEY_EN is defined
//   - low_idx() : index of the lowest-numbered low bit of an active-low vector
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [3:0] CLEAR_KEY_CODE = 4'hF;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } scan_state_t;

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    DONE   = 2'd2
  } seq_state_t;

  // Lowest index wins when several lines are low at once.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce
//   Press/release debouncer for the scanned keypad. Tracks the captured row
//   pattern and a stability counter, and flags when a press is accepted or a
//   release has settled.
//   Ports:
//     clk_sys       in   clock, rising edge
//     rst_b         in   synchronous active-low reset
//     row[3:0]      in   keypad rows, active-low
//     state         out  current scanner state (column scan freezes outside SCAN)
//     press_accept  out  combinational strobe, true on the edge a press is accepted
//     release_done  out  combinational strobe, true on the edge a release settles
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   SCAN       | no key seen, columns rotating
//   PRESS_DB   | a row is low, counting identical samples of the pattern
//   HELD       | key accepted, waiting for all rows high
//   RELEASE_DB | rows high, counting all-high samples before rescanning
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk_sys,
  input  logic        rst_b,
  input  logic [3:0]  row,
  output scan_state_t state,
  output logic        press_accept,
  output logic        release_done
);

  localparam logic [3:0] DB_W = 4'(DEBOUNCE_CYCLES);

  scan_state_t state_nx;
  logic [3:0]  pattern, pattern_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        row_idle;

  assign row_idle = &row;

  // The count includes the current sample, so a press is accepted on the
  // edge that sees the DEBOUNCE_CYCLES-th identical low pattern.
  always_comb begin
    state_nx     = state;
    pattern_nx   = pattern;
    cnt_nx       = cnt;
    press_accept = 1'b0;
    release_done = 1'b0;
    case (state)
      SCAN: begin
        if (!row_idle) begin
          pattern_nx = row;
          cnt_nx     = 4'd1;
          state_nx   = PRESS_DB;
          if (cnt_nx == DB_W) begin
            press_accept = 1'b1;
            state_nx     = HELD;
            cnt_nx       = 4'd0;
          end
        end
      end
      PRESS_DB: begin
        if (row_idle) begin
          state_nx = SCAN;
          cnt_nx   = 4'd0;
        end else begin
          if (row != pattern) begin
            pattern_nx = row;
            cnt_nx     = 4'd1;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
          if (cnt_nx == DB_W) begin
            press_accept = 1'b1;
            state_nx     = HELD;
            cnt_nx       = 4'd0;
          end
        end
      end
      HELD: begin
        if (row_idle) begin
          cnt_nx   = 4'd1;
          state_nx = RELEASE_DB;
          if (cnt_nx == DB_W) begin
            release_done = 1'b1;
            state_nx     = SCAN;
            cnt_nx       = 4'd0;
          end
        end
      end
      RELEASE_DB: begin
        if (!row_idle) begin
          state_nx = HELD;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
          if (cnt_nx == DB_W) begin
            release_done = 1'b1;
            state_nx     = SCAN;
            cnt_nx       = 4'd0;
          end
        end
      end
      default: begin
        state_nx = SCAN;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      state   <= SCAN;
      pattern <= 4'hF;
      cnt     <= 4'd0;
    end else begin
      state   <= state_nx;
      pattern <= pattern_nx;
      cnt     <= cnt_nx;
    end
  end

endmodule

// File: rtl/keypad_operand_loader.sv
// keypad_operand_loader
//   Scans a 4x4 hex keypad, debounces it, encodes the accepted key and
//   sequences operand entry: first key loads accumulator A, second loads B,
//   then OperandsValid is raised until Restart.
//   Parameters: DEBOUNCE_CYCLES (1..15), SCAN_DIV (1..15).
//   Optional build macro: KEYPAD_CLEAR_KEY_EN -- key 4'hF becomes a clear key
//   that returns to WAIT_A and pulses the extra active-low ClearOut output.
//   Ports:
//     MainClock      in   clock, rising edge
//     ClearN         in   synchronous active-low reset
//     Row[3:0]       in   keypad rows, active-low
//     Restart        in   one-cycle request to restart operand entry
//     Col[3:0]       out  column drive, active-low one-hot
//     kbd[3:0]       out  encoded key value, held until the next loaded key
//     LatchA         out  one-cycle load pulse for accumulator A
//     LatchB         out  one-cycle load pulse for accumulator B
//     OperandsValid  out  both operands loaded
//     ClearOut       out  one-cycle active-low clear pulse (KEYPAD_CLEAR_KEY_EN only)
//
//   state  | meaning
//   -------+--------------------------------------------
//   WAIT_A | next accepted key loads accumulator A
//   WAIT_B | next accepted key loads accumulator B
//   DONE   | both loaded, keys ignored until Restart
module keypad_operand_loader
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DIV        = 1
) (
  input  logic                MainClock,
  input  logic                ClearN,
  input  logic [NUM_ROWS-1:0] Row,
  input  logic                Restart,
  output logic [NUM_COLS-1:0] Col,
  output logic [3:0]          kbd,
  output logic                LatchA,
  output logic                LatchB,
  output logic                OperandsValid
`ifdef KEYPAD_CLEAR_KEY_EN
  ,
  output logic                ClearOut
`endif
);

  localparam logic [3:0] DIV_LAST = 4'(SCAN_DIV - 1);

  scan_state_t scan_state;
  seq_state_t  seq;
  logic        press_accept;
  logic        release_done;
  logic [3:0]  div_cnt;
  logic        scan_step;
  logic [3:0]  code;
  logic        is_clear;
  logic        pend_a, pend_b;
`ifdef KEYPAD_CLEAR_KEY_EN
  logic        pend_clr;
`endif

  keypad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_sys      (MainClock),
    .rst_b        (ClearN),
    .row          (Row),
    .state        (scan_state),
    .press_accept (press_accept),
    .release_done (release_done)
  );

  // Column only moves while idle in SCAN; any low row freezes it so the
  // pressed key stays visible through debounce.
  assign scan_step = (scan_state == SCAN) && (&Row);

  always_ff @(posedge MainClock) begin
    if (!ClearN) begin
      Col     <= 4'b1110;
      div_cnt <= 4'd0;
    end else if (release_done) begin
      Col     <= {Col[2:0], Col[3]};
      div_cnt <= 4'd0;
    end else if (scan_step) begin
      if (div_cnt == DIV_LAST) begin
        Col     <= {Col[2:0], Col[3]};
        div_cnt <= 4'd0;
      end else begin
        div_cnt <= div_cnt + 4'd1;
      end
    end
  end

  assign code = {low_idx(Row), low_idx(Col)};

`ifdef KEYPAD_CLEAR_KEY_EN
  assign is_clear = (code == CLEAR_KEY_CODE);
`else
  assign is_clear = 1'b0;
`endif

  // kbd loads on the accept edge; the matching pulse leaves one edge later
  // through pend_*, so kbd is settled a full cycle before the pulse.
  always_ff @(posedge MainClock) begin
    if (!ClearN) begin
      seq           <= WAIT_A;
      kbd           <= 4'd0;
      pend_a        <= 1'b0;
      pend_b        <= 1'b0;
      LatchA        <= 1'b0;
      LatchB        <= 1'b0;
      OperandsValid <= 1'b0;
`ifdef KEYPAD_CLEAR_KEY_EN
      pend_clr      <= 1'b0;
      ClearOut      <= 1'b1;
`endif
    end else begin
      LatchA <= pend_a;
      LatchB <= pend_b;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
`ifdef KEYPAD_CLEAR_KEY_EN
      ClearOut <= ~pend_clr;
      pend_clr <= 1'b0;
`endif
      if (pend_b) OperandsValid <= 1'b1;
      // Restart outranks an accept on the same edge.
      if (Restart) begin
        seq           <= WAIT_A;
        OperandsValid <= 1'b0;
      end else if (press_accept) begin
        if (is_clear) begin
          seq           <= WAIT_A;
          OperandsValid <= 1'b0;
`ifdef KEYPAD_CLEAR_KEY_EN
          pend_clr      <= 1'b1;
`endif
        end else begin
          case (seq)
            WAIT_A: begin
              kbd    <= code;
              pend_a <= 1'b1;
              seq    <= WAIT_B;
            end
            WAIT_B: begin
              kbd    <= code;
              pend_b <= 1'b1;
              seq    <= DONE;
            end
            DONE: ;
            default: seq <= WAIT_A;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_operand_loader.sv
// tb_keypad_operand_loader
//   Keypad matrix model drives Row from Col and a pressed key; a scoreboard
//   holds the expected pulse kind and kbd value for every loaded key and a
//   monitor pops/compares on each observed pulse.
module tb_keypad_operand_loader;

  localparam int DB = 4;
  localparam int SD = 1;

  localparam logic [2:0] K_A   = 3'b100;
  localparam logic [2:0] K_B   = 3'b010;
  localparam logic [2:0] K_CLR = 3'b001;

  typedef struct packed {
    logic [2:0] kind;
    logic [3:0] kbd;
  } exp_t;

  logic       MainClock = 1'b0;
  logic       ClearN    = 1'b0;
  logic       Restart   = 1'b0;
  logic [3:0] Row;
  logic [3:0] Col;
  logic [3:0] kbd;
  logic       LatchA;
  logic       LatchB;
  logic       OperandsValid;
  logic       clr_pulse;

  logic       key_down = 1'b0;
  logic [1:0] key_r    = 2'd0;
  logic [1:0] key_c    = 2'd0;

  exp_t       sb[$];
  exp_t       e;
  logic [2:0] p;
  logic [3:0] kbd_prev   = 4'd0;
  logic       prev_pulse = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef KEYPAD_CLEAR_KEY_EN
  logic ClearOut;
  assign clr_pulse = ~ClearOut;
`else
  assign clr_pulse = 1'b0;
`endif

  keypad_operand_loader #(
    .DEBOUNCE_CYCLES(DB),
    .SCAN_DIV       (SD)
  ) dut (
    .MainClock    (MainClock),
    .ClearN       (ClearN),
    .Row          (Row),
    .Restart      (Restart),
    .Col          (Col),
    .kbd          (kbd),
    .LatchA       (LatchA),
    .LatchB       (LatchB),
    .OperandsValid(OperandsValid)
`ifdef KEYPAD_CLEAR_KEY_EN
    ,
    .ClearOut     (ClearOut)
`endif
  );

  always #5 MainClock = ~MainClock;

  always_comb begin
    Row = 4'hF;
    if (key_down && (Col[key_c] == 1'b0)) Row = ~(4'b0001 << key_r);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_pulse(input logic [2:0] kind, input logic [3:0] v);
    sb.push_back({kind, v});
  endtask

  task automatic wait_col(input logic [1:0] c);
    int n = 0;
    while (Col[c] !== 1'b0 && n < 20) begin
      @(negedge MainClock);
      n++;
    end
    check_eq("wait_col", 32'(Col[c]), 32'd0);
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c, input int hold);
    key_r = r;
    key_c = c;
    wait_col(c);
    key_down = 1'b1;
    repeat (hold) @(negedge MainClock);
    key_down = 1'b0;
    repeat (10) @(negedge MainClock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_col"}, 32'(Col), 32'hE);
    check_eq({tag, "_kbd"}, 32'(kbd), 32'h0);
    check_eq({tag, "_latcha"}, 32'(LatchA), 32'd0);
    check_eq({tag, "_latchb"}, 32'(LatchB), 32'd0);
    check_eq({tag, "_valid"}, 32'(OperandsValid), 32'd0);
`ifdef KEYPAD_CLEAR_KEY_EN
    check_eq({tag, "_clearout"}, 32'(ClearOut), 32'd1);
`endif
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue, be a
  // single cycle wide and see kbd already stable in the previous cycle.
  always @(negedge MainClock) begin
    p = {LatchA, LatchB, clr_pulse};
    if (p != 3'b000) begin
      check_eq("pulse_width", 32'(prev_pulse), 32'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", 32'(p), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("pulse_kind", 32'(p), 32'(e.kind));
        check_eq("kbd_at_pulse", 32'(kbd), 32'(e.kbd));
        check_eq("kbd_setup", 32'(kbd_prev), 32'(e.kbd));
      end
    end
    prev_pulse = |p;
    kbd_prev   = kbd;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] col_seq [4];
    int n;
    col_seq[0] = 4'hD;
    col_seq[1] = 4'hB;
    col_seq[2] = 4'h7;
    col_seq[3] = 4'hE;

    // Reset and idle column scan
    repeat (3) @(negedge MainClock);
    check_reset_outputs("reset");
    ClearN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge MainClock);
      check_eq("col_scan", 32'(Col), 32'(col_seq[i]));
    end
    check_eq("idle_latcha", 32'(LatchA), 32'd0);
    check_eq("idle_valid", 32'(OperandsValid), 32'd0);

    // Two operands: row1/col2 -> A, row3/col0 -> B
    expect_pulse(K_A, 4'h6);
    press(2'd1, 2'd2, 10);
    check_eq("after_a_valid", 32'(OperandsValid), 32'd0);
    expect_pulse(K_B, 4'hC);
    press(2'd3, 2'd0, 10);
    check_eq("after_b_valid", 32'(OperandsValid), 32'd1);

    // In DONE further keys are ignored
    press(2'd0, 2'd3, 10);
    check_eq("done_kbd", 32'(kbd), 32'hC);
    check_eq("done_valid", 32'(OperandsValid), 32'd1);

    // Restart clears OperandsValid on the next cycle
    Restart = 1'b1;
    @(negedge MainClock);
    Restart = 1'b0;
    check_eq("restart_valid", 32'(OperandsValid), 32'd0);

    // Bouncy press on row2/col1: low 2, high 1, low 6; pulse timed from last run
    expect_pulse(K_A, 4'h9);
    key_r = 2'd2;
    key_c = 2'd1;
    wait_col(2'd1);
    key_down = 1'b1;
    repeat (2) @(negedge MainClock);
    key_down = 1'b0;
    @(negedge MainClock);
    key_down = 1'b1;
    n = 0;
    do begin
      @(negedge MainClock);
      n++;
    end while (LatchA !== 1'b1 && n < 20);
    check_eq("bounce_latch_delay", 32'(n), 32'd5);
    @(negedge MainClock);
    // Bouncy release: high 2, low 1, high until settled
    key_down = 1'b0;
    repeat (2) @(negedge MainClock);
    key_down = 1'b1;
    @(negedge MainClock);
    key_down = 1'b0;
    repeat (12) @(negedge MainClock);
    check_eq("bounce_sb_empty", 32'(sb.size()), 32'd0);
    check_eq("bounce_valid", 32'(OperandsValid), 32'd0);

    // Second operand after the bounce sequence
    expect_pulse(K_B, 4'hB);
    press(2'd2, 2'd3, 10);
    check_eq("second_b_valid", 32'(OperandsValid), 32'd1);

    // Restart, then Restart coinciding with an accept discards the key
    Restart = 1'b1;
    @(negedge MainClock);
    Restart = 1'b0;
    check_eq("restart2_valid", 32'(OperandsValid), 32'd0);
    key_r = 2'd1;
    key_c = 2'd1;
    wait_col(2'd1);
    key_down = 1'b1;
    repeat (3) @(negedge MainClock);
    Restart = 1'b1;
    @(negedge MainClock);
    Restart = 1'b0;
    repeat (4) @(negedge MainClock);
    key_down = 1'b0;
    repeat (10) @(negedge MainClock);
    check_eq("collide_kbd", 32'(kbd), 32'hB);
    check_eq("collide_valid", 32'(OperandsValid), 32'd0);

    // ClearN asserted while PRESS_DB count is 3
    key_r = 2'd3;
    key_c = 2'd2;
    wait_col(2'd2);
    key_down = 1'b1;
    repeat (3) @(negedge MainClock);
    ClearN = 1'b0;
    @(negedge MainClock);
    check_reset_outputs("midreset");
    key_down = 1'b0;
    ClearN   = 1'b1;
    repeat (6) @(negedge MainClock);

    // After reset the first key goes to A
    expect_pulse(K_A, 4'h1);
    press(2'd0, 2'd1, 10);
    check_eq("post_reset_valid", 32'(OperandsValid), 32'd0);

    // Key row3/col3
`ifdef KEYPAD_CLEAR_KEY_EN
    expect_pulse(K_CLR, 4'h1);
    press(2'd3, 2'd3, 10);
    check_eq("clear_kbd", 32'(kbd), 32'h1);
    expect_pulse(K_A, 4'h2);
    press(2'd0, 2'd2, 10);
    check_eq("clear_then_a_valid", 32'(OperandsValid), 32'd0);
`else
    expect_pulse(K_B, 4'hF);
    press(2'd3, 2'd3, 10);
    check_eq("key_f_valid", 32'(OperandsValid), 32'd1);
`endif

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
